// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: execute request, data-memory bus and writeback response.
// slave = load/store unit side, master = execute/memory/writeback side.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_base;
  logic [11:0]       req_imm;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              mem_wr;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_funct3;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic [4:0]        resp_rd;
  logic              resp_err_funct3;
  logic              resp_err_misalign;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_funct3, req_base,
    input  req_imm, req_wdata, req_rd, mem_rdata,
    output req_ready, mem_wr, mem_read, mem_addr,
    output mem_wdata, mem_funct3, resp_valid, resp_data,
    output resp_rd, resp_err_funct3, resp_err_misalign, busy
  );

  modport master (
    output req_valid, req_we, req_funct3, req_base,
    output req_imm, req_wdata, req_rd, mem_rdata,
    input  req_ready, mem_wr, mem_read, mem_addr,
    input  mem_wdata, mem_funct3, resp_valid, resp_data,
    input  resp_rd, resp_err_funct3, resp_err_misalign, busy
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage in front of data memory.
// Ports: clk, rst (sync, active-high), bus (lsu_ctrl_if.slave:
// req handshake in, mem bus out, resp pulse out).
// Option: LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses
// instead of splitting them into byte accesses.
module lsu_ctrl #(
  parameter int ADDR_W = 12
) (
  input logic      clk,
  input logic      rst,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] ea, ea_n;
  logic              we;
  logic [2:0]        f3;
  logic [31:0]       wdata;
  logic [4:0]        rd;
  logic              mis;
  logic [1:0]        k;
  logic [31:0]       asm_q;
  logic [31:0]       res;
  logic              err_f3;
  logic              err_mis;

  logic        accept;
  logic        legal_n;
  logic        mis_n;
  logic        trap_n;
  logic [31:0] imm_ext;
  logic [31:0] sum;
  logic [1:0]  last_k;
  logic        last;
  logic [7:0]  wbyte;
  logic [31:0] full;
  logic [31:0] ext;

  always_comb begin
    imm_ext = {{20{bus.req_imm[11]}}, bus.req_imm};
    sum     = bus.req_base + imm_ext;
    ea_n    = sum[ADDR_W-1:0];
    case (bus.req_funct3)
      3'd0, 3'd1, 3'd2: legal_n = 1'b1;
      3'd4, 3'd5:       legal_n = !bus.req_we;
      default:          legal_n = 1'b0;
    endcase
    mis_n = legal_n &&
      ((bus.req_funct3[1:0] == 2'd1 && ea_n[0]) ||
       (bus.req_funct3[1:0] == 2'd2 && ea_n[1:0] != 2'd0));
`ifdef LSU_MISALIGN_TRAP_EN
    trap_n = mis_n;
`else
    trap_n = 1'b0;
`endif
  end

  // Split accesses walk k up to the last byte of the half/word.
  always_comb begin
    last_k = 2'd0;
    if (mis)
      last_k = (f3[1:0] == 2'd2) ? 2'd3 : 2'd1;
    last  = (k == last_k);
    wbyte = wdata[{k, 3'b000} +: 8];
    full  = bus.mem_rdata;
    if (mis) begin
      full = asm_q;
      full[{k, 3'b000} +: 8] = bus.mem_rdata[7:0];
    end
    unique case (1'b1)
      f3 == 3'd0: ext = {{24{full[7]}}, full[7:0]};
      f3 == 3'd1: ext = {{16{full[15]}}, full[15:0]};
      f3 == 3'd4: ext = {24'h0, full[7:0]};
      f3 == 3'd5: ext = {16'h0, full[15:0]};
      default:    ext = full;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n               = state;
    accept                = 1'b0;
    bus.req_ready         = 1'b0;
    bus.mem_wr            = 1'b0;
    bus.mem_read          = 1'b0;
    bus.mem_addr          = '0;
    bus.mem_wdata         = '0;
    bus.mem_funct3        = '0;
    bus.resp_valid        = 1'b0;
    bus.resp_data         = '0;
    bus.resp_rd           = '0;
    bus.resp_err_funct3   = 1'b0;
    bus.resp_err_misalign = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_n = (!legal_n || trap_n) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_wr   = we;
        bus.mem_read = !we;
        bus.mem_addr = ea + ADDR_W'(k);
        if (mis) begin
          bus.mem_funct3 = we ? 3'd0 : 3'd4;
          bus.mem_wdata  = {24'h0, wbyte};
        end else begin
          bus.mem_funct3 = f3;
          bus.mem_wdata  = wdata;
        end
        if (last) state_n = RESP;
      end
      RESP: begin
        bus.resp_valid        = 1'b1;
        bus.resp_data         = res;
        bus.resp_err_funct3   = err_f3;
        bus.resp_err_misalign = err_mis;
        if (!we && !err_f3 && !err_mis)
          bus.resp_rd = rd;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    bus.busy = !bus.req_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ea      <= '0;
      we      <= 1'b0;
      f3      <= '0;
      wdata   <= '0;
      rd      <= '0;
      mis     <= 1'b0;
      k       <= '0;
      asm_q   <= '0;
      res     <= '0;
      err_f3  <= 1'b0;
      err_mis <= 1'b0;
    end else if (accept) begin
      ea      <= ea_n;
      we      <= bus.req_we;
      f3      <= bus.req_funct3;
      wdata   <= bus.req_wdata;
      rd      <= bus.req_rd;
      mis     <= mis_n && !trap_n;
      k       <= '0;
      asm_q   <= '0;
      res     <= '0;
      err_f3  <= !legal_n;
      err_mis <= trap_n;
    end else if (state == ACCESS) begin
      k <= k + 2'd1;
      if (!we) begin
        if (mis)  asm_q <= full;
        if (last) res   <= ext;
      end
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus random load/store traffic against a
// byte-array memory and a reference model of the access rules.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(12)) bus();
  lsu_ctrl #(.ADDR_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem  [4096];
  logic [7:0] rmem [4096];
  int total = 0;
  int bad   = 0;

  logic [11:0] gaddr[$];
  logic [2:0]  gf3[$];
  logic [31:0] gwd[$];
  logic        gwr[$];

  int          r_lat;
  logic [31:0] r_data;
  logic [4:0]  r_rd;
  logic        r_ef3;
  logic        r_emis;

  logic [11:0] ma;
  always_comb begin
    ma = bus.mem_addr;
    case (bus.mem_funct3)
      3'd0, 3'd4: bus.mem_rdata = {24'h0, mem[ma]};
      3'd1, 3'd5: bus.mem_rdata = {16'h0, mem[ma+12'd1], mem[ma]};
      default:    bus.mem_rdata = {mem[ma+12'd3], mem[ma+12'd2],
                                   mem[ma+12'd1], mem[ma]};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after each falling edge: log accesses, apply writes.
  task automatic sample();
    logic [11:0] a;
    a = bus.mem_addr;
    chk("busy", {31'h0, bus.busy}, {31'h0, !bus.req_ready});
    if (bus.mem_wr || bus.mem_read) begin
      gaddr.push_back(a);
      gf3.push_back(bus.mem_funct3);
      gwd.push_back(bus.mem_wdata);
      gwr.push_back(bus.mem_wr);
    end
    if (bus.mem_wr) begin
      mem[a] = bus.mem_wdata[7:0];
      if (bus.mem_funct3 != 3'd0)
        mem[a+12'd1] = bus.mem_wdata[15:8];
      if (bus.mem_funct3 == 3'd2) begin
        mem[a+12'd2] = bus.mem_wdata[23:16];
        mem[a+12'd3] = bus.mem_wdata[31:24];
      end
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] base,
                         input logic [11:0] imm,
                         input logic [31:0] wd, input logic [4:0] rd);
    logic [11:0] ea;
    int n, elat, nacc;
    bit legal, mis, trap;
    logic [31:0] v, ed;
    logic [4:0]  erd;
    logic [11:0] eaddr[$];
    logic [2:0]  ef3[$];
    logic [31:0] ewd[$];
    ea    = 12'(base + {{20{imm[11]}}, imm});
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = legal && (int'(ea) % n != 0);
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = mis;
`endif
    ed = 0;
    erd = 0;
    if (!legal || trap) begin
      elat = 1;
    end else begin
      if (!mis) begin
        elat = 2;
        eaddr.push_back(ea);
        ef3.push_back(f3);
        ewd.push_back(wd);
      end else begin
        elat = n + 1;
        for (int i = 0; i < n; i++) begin
          eaddr.push_back(ea + 12'(i));
          ef3.push_back(we ? 3'd0 : 3'd4);
          ewd.push_back((wd >> (8 * i)) & 32'hFF);
        end
      end
      if (we) begin
        for (int i = 0; i < n; i++)
          rmem[ea+12'(i)] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = v | (32'(rmem[ea+12'(i)]) << (8 * i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        ed  = v;
        erd = rd;
      end
    end

    for (int w = 0; w < 8 && !bus.req_ready; w++) begin
      @(negedge clk);
      sample();
    end
    chk("ready", {31'h0, bus.req_ready}, 32'h1);
    gaddr.delete(); gf3.delete(); gwd.delete(); gwr.delete();
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_base   = base;
    bus.req_imm    = imm;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_base   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_rd     = 5'($urandom);
    r_lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      sample();
      if (bus.resp_valid) begin
        r_lat  = i;
        r_data = bus.resp_data;
        r_rd   = bus.resp_rd;
        r_ef3  = bus.resp_err_funct3;
        r_emis = bus.resp_err_misalign;
        break;
      end
    end
    chk("latency", r_lat, elat);
    chk("data", r_data, ed);
    chk("rd", {27'h0, r_rd}, {27'h0, erd});
    chk("err_f3", {31'h0, r_ef3}, {31'h0, !legal});
    chk("err_mis", {31'h0, r_emis}, {31'h0, trap});
    nacc = gaddr.size();
    chk("n_access", nacc, eaddr.size());
    for (int i = 0; i < nacc && i < eaddr.size(); i++) begin
      chk("acc_addr", {20'h0, gaddr[i]}, {20'h0, eaddr[i]});
      chk("acc_f3", {29'h0, gf3[i]}, {29'h0, ef3[i]});
      chk("acc_wr", {31'h0, gwr[i]}, {31'h0, we});
      if (we) chk("acc_wd", gwd[i], ewd[i]);
    end
    for (int i = 0; i < 4; i++)
      chk("mem", {24'h0, mem[ea+12'(i)]}, {24'h0, rmem[ea+12'(i)]});
    @(negedge clk);
    sample();
    chk("pulse", {31'h0, bus.resp_valid}, 32'h0);
  endtask

  initial begin
    logic [7:0] old [4];
    bit seen;
    rst = 1'b1;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
    bus.req_base = 0; bus.req_imm = 0; bus.req_wdata = 0;
    bus.req_rd = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]  = 8'($urandom);
      rmem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_wr", {31'h0, bus.mem_wr}, 32'h0);
    chk("rst_rd", {31'h0, bus.mem_read}, 32'h0);
    chk("rst_resp", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_data", bus.resp_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_req(1, 3'd2, 32'h100, 12'h004, 32'hDEADBEEF, 5'd0);
    chk("sw_lat", r_lat, 2);
    run_req(0, 3'd2, 32'h100, 12'h004, 32'h0, 5'd5);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_rd", {27'h0, r_rd}, 32'd5);
    run_req(1, 3'd2, 32'h104, 12'h000, 32'h0000_80FF, 5'd0);
    run_req(0, 3'd0, 32'h105, 12'h000, 32'h0, 5'd7);
    chk("lb", r_data, 32'hFFFF_FF80);
    run_req(0, 3'd4, 32'h105, 12'h000, 32'h0, 5'd7);
    chk("lbu", r_data, 32'h0000_0080);
    run_req(1, 3'd1, 32'h103, 12'h000, 32'h0000_A5C3, 5'd0);
    run_req(0, 3'd1, 32'h103, 12'h000, 32'h0, 5'd9);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lh_data", r_data, 32'hFFFF_A5C3);
    chk("lh_lat", r_lat, 3);
`endif
    run_req(0, 3'd2, 32'h0000_0FFE, 12'h000, 32'h0, 5'd3);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("wrap_lat", r_lat, 5);
`else
    chk("trap_lat", r_lat, 1);
`endif
    run_req(0, 3'd3, 32'h100, 12'h000, 32'h0, 5'd4);
    chk("ill_lat", r_lat, 1);
    run_req(0, 3'd2, 32'h200, 12'hFFC, 32'h0, 5'd1);

    for (int i = 0; i < 4; i++) old[i] = mem[12'h201 + 12'(i)];
    bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'd2;
    bus.req_base = 32'h201; bus.req_imm = 0;
    bus.req_wdata = 32'h1122_3344; bus.req_rd = 0;
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    rst = 1'b1;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample();
      if (i == 0) begin
        chk("abort_wr", {31'h0, bus.mem_wr}, 32'h0);
        chk("abort_ready", {31'h0, bus.req_ready}, 32'h1);
      end
      if (bus.resp_valid) seen = 1;
    end
    chk("abort_noresp", {31'h0, seen}, 32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("abort_b0", {24'h0, mem[12'h201]}, 32'h44);
    rmem[12'h201] = 8'h44;
`else
    chk("abort_b0", {24'h0, mem[12'h201]}, {24'h0, old[0]});
`endif
    for (int i = 1; i < 4; i++)
      chk("abort_bn", {24'h0, mem[12'h201 + 12'(i)]}, {24'h0, old[i]});

    for (int t = 0; t < 150; t++) begin
      logic [2:0] f;
      logic w;
      w = 1'($urandom);
      f = 3'($urandom);
      if ($urandom_range(0, 9) < 8)
        f = w ? 3'($urandom_range(0, 2)) : ($urandom_range(0, 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
      run_req(w, f, $urandom, 12'($urandom), $urandom, 5'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        sample();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
